// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
// Bundles the request channels, response channels and shared-ALU connection
// of alu_share_arbiter.  All two-requester buses are packed with requester i
// at slice [i*W +: W].
//   master : requester/ALU side (drives requests, response accepts, ALU result)
//   slave  : arbiter side (drives accepts, responses, ALU operands/control)
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    // Request channels
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*XLEN-1:0]  req_a;
    logic [2*XLEN-1:0]  req_b;
    logic [2*5-1:0]     req_op;
    logic [2*TAG_W-1:0] req_tag;

    // Shared ALU connection
    logic [XLEN-1:0]    alu_src_a;
    logic [XLEN-1:0]    alu_src_b;
    logic [4:0]         alu_ctrl;
    logic [XLEN-1:0]    alu_result;
    logic               alu_zero;
    logic               alu_negative;

    // Response channels
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [2*XLEN-1:0]  rsp_result;
    logic [1:0]         rsp_zero;
    logic [1:0]         rsp_negative;
    logic [2*TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag,
        output rsp_ready,
        output alu_result, alu_zero, alu_negative,
        input  req_ready,
        input  alu_src_a, alu_src_b, alu_ctrl,
        input  rsp_valid, rsp_result, rsp_zero, rsp_negative, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag,
        input  rsp_ready,
        input  alu_result, alu_zero, alu_negative,
        output req_ready,
        output alu_src_a, alu_src_b, alu_ctrl,
        output rsp_valid, rsp_result, rsp_zero, rsp_negative, rsp_tag
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two requesters.  A round-robin grant
// picks at most one eligible request per cycle, steers its operands/control
// onto the ALU, and captures result, flags and tag into that requester's
// registered response slot (1-cycle latency).  Each requester has its own
// slot, so a stalled response on one side never blocks the other.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus          alu_share_arbiter_if.slave: request, response and ALU signals
//   stats_clr    (ALU_ARB_STATS_EN only) synchronous clear of grant counters
//   grant_cnt0/1 (ALU_ARB_STATS_EN only) saturating 16-bit grant counters
//
// Optional feature macro: ALU_ARB_STATS_EN (grant statistics counters).
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ALU_ARB_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1,
`endif
    alu_share_arbiter_if.slave bus
);

    localparam logic [4:0] OP_ADD = 5'b00010;

    logic               last_grant_q, last_grant_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [2*XLEN-1:0]  rsp_result_q, rsp_result_d;
    logic [1:0]         rsp_zero_q, rsp_zero_d;
    logic [1:0]         rsp_negative_q, rsp_negative_d;
    logic [2*TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic [1:0] slot_free;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       gidx;

    // Grant depends only on control: valids, slot state and the rr pointer.
    // A slot being popped this cycle counts as free (pop-and-refill).
    always_comb begin
        slot_free = ~rsp_valid_q | bus.rsp_ready;
        eligible  = bus.req_valid & slot_free;
        unique case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        gidx = grant[1];
    end

    assign bus.req_ready = grant;

    // ALU operand steering; an idle ALU sees a harmless ADD of zeros.
    always_comb begin
        bus.alu_src_a = '0;
        bus.alu_src_b = '0;
        bus.alu_ctrl  = OP_ADD;
        if (|grant) begin
            bus.alu_src_a = gidx ? bus.req_a[2*XLEN-1:XLEN] : bus.req_a[XLEN-1:0];
            bus.alu_src_b = gidx ? bus.req_b[2*XLEN-1:XLEN] : bus.req_b[XLEN-1:0];
            bus.alu_ctrl  = gidx ? bus.req_op[9:5]          : bus.req_op[4:0];
        end
    end

    // Response slot next-state: a grant refills, a pop without grant empties,
    // otherwise the slot holds its contents.
    always_comb begin
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_negative_d = rsp_negative_q;
        rsp_tag_d      = rsp_tag_q;
        last_grant_d   = last_grant_q;
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
                rsp_valid_d[i]                   = 1'b1;
                rsp_result_d[i*XLEN +: XLEN]     = bus.alu_result;
                rsp_zero_d[i]                    = bus.alu_zero;
                rsp_negative_d[i]                = bus.alu_negative;
                rsp_tag_d[i*TAG_W +: TAG_W]      = bus.req_tag[i*TAG_W +: TAG_W];
            end else if (bus.rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
        if (|grant) begin
            last_grant_d = gidx;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q   <= 1'b1;
            rsp_valid_q    <= '0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= '0;
            rsp_negative_q <= '0;
            rsp_tag_q      <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_negative_q <= rsp_negative_d;
            rsp_tag_q      <= rsp_tag_d;
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_negative = rsp_negative_q;
    assign bus.rsp_tag      = rsp_tag_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Clear has priority over increment; counters stick at all-ones.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (stats_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (grant[0] && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
            if (grant[1] && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule
